// File: rtl/sent_tx_crc_engine.sv
// sent_tx_crc_engine
//   CRC generator for the SENT transmitter. Produces the SAE J2716 CRC4
//   (fast-channel frames, short serial messages) or the CRC6 (enhanced
//   serial messages) over up to MAX_NIBBLES data nibbles, one nibble per
//   clock. A message of N nibbles gives its result N+2 cycles after start.
//
//   Optional feature macro: SENT_CRC_LEGACY_EN
//     When defined, adds input legacy_crc. With legacy_crc = 1 and CRC4 mode
//     the result is the J2716-2007 legacy CRC4 (no zero augmentation).
//
// Handshake: start is sampled only in IDLE. busy is high from the cycle
//   after acceptance until the DONE cycle. In DONE exactly one of crc_valid
//   (with crc_out) or crc_err pulses for one cycle; crc_out holds its value
//   until the next successful result.
//
// Ports:
//   clk_tx      in   TX clock, rising edge
//   reset_tx    in   synchronous reset, active-low
//   start       in   one-cycle request, sampled in IDLE
//   crc_mode    in   0 = CRC4 (x^4+x^3+x^2+1), 1 = CRC6 (x^6+x^4+x^3+1)
//   nibble_cnt  in   number of data nibbles, legal 1..MAX_NIBBLES
//   data_in     in   data, first nibble at [4*nibble_cnt-1 -: 4]
//   legacy_crc  in   (SENT_CRC_LEGACY_EN only) select legacy CRC4
//   busy        out  message in progress
//   crc_out     out  result, CRC4 in [3:0] with [5:4] = 0
//   crc_valid   out  one-cycle result pulse
//   crc_err     out  one-cycle pulse for an illegal nibble_cnt
module sent_tx_crc_engine #(
    parameter int         MAX_NIBBLES = 6,
    parameter logic [3:0] CRC4_SEED   = 4'h5,
    parameter logic [5:0] CRC6_SEED   = 6'h15
) (
    input  logic                     clk_tx,
    input  logic                     reset_tx,
    input  logic                     start,
    input  logic                     crc_mode,
    input  logic [3:0]               nibble_cnt,
    input  logic [4*MAX_NIBBLES-1:0] data_in,
`ifdef SENT_CRC_LEGACY_EN
    input  logic                     legacy_crc,
`endif
    output logic                     busy,
    output logic [5:0]               crc_out,
    output logic                     crc_valid,
    output logic                     crc_err
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    localparam logic [3:0] MAX_N4 = 4'(MAX_NIBBLES);

    // Multiply the seed by x^k modulo P so that the non-augmented LFSR ends
    // up with the same remainder as the augmented {seed, data, k zeros} form.
    function automatic logic [5:0] init_value(input logic mode, input logic [5:0] seed);
        logic [5:0] c;
        c = seed;
        for (int i = 0; i < 6; i++) begin
            if (mode) begin
                c = {c[4:0], 1'b0} ^ (c[5] ? 6'h19 : 6'h00);
            end else if (i < 4) begin
                c = {2'b00, c[2:0], 1'b0} ^ (c[3] ? 6'h0D : 6'h00);
            end
        end
        return c;
    endfunction

    localparam logic [5:0] CRC4_INIT = init_value(1'b0, {2'b00, CRC4_SEED});
    localparam logic [5:0] CRC6_INIT = init_value(1'b1, CRC6_SEED);

    // Fold one nibble, MSB first. The legacy form is a plain long-division
    // register (data shifted in, no augmentation), seeded with the raw seed.
    function automatic logic [5:0] fold(input logic [5:0] crc, input logic [3:0] nib,
                                        input logic mode, input logic legacy);
        logic [5:0] c;
        logic       fb;
        c = crc;
        for (int i = 3; i >= 0; i--) begin
            if (legacy) begin
                fb = c[3];
                c  = {2'b00, c[2:0], nib[i]} ^ (fb ? 6'h0D : 6'h00);
            end else if (!mode) begin
                fb = c[3] ^ nib[i];
                c  = {2'b00, c[2:0], 1'b0} ^ (fb ? 6'h0D : 6'h00);
            end else begin
                fb = c[5] ^ nib[i];
                c  = {c[4:0], 1'b0} ^ (fb ? 6'h19 : 6'h00);
            end
        end
        return c;
    endfunction

    state_t                   state_q, state_d;
    logic                     mode_q;
    logic [3:0]               nib_q;
    logic [4*MAX_NIBBLES-1:0] data_q;
    logic [3:0]               cnt_q;
    logic [5:0]               lfsr_q;
    logic                     err_q;
    logic                     legacy_eff;
    logic [3:0]               cur_nib;
    logic [5:0]               lfsr_nxt;
    logic                     cnt_illegal;

`ifdef SENT_CRC_LEGACY_EN
    logic legacy_q;
    always_ff @(posedge clk_tx) begin
        if (!reset_tx) begin
            legacy_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            legacy_q <= legacy_crc & ~crc_mode;
        end
    end
    assign legacy_eff = legacy_q;
`else
    assign legacy_eff = 1'b0;
`endif

    assign cnt_illegal = (nib_q == 4'd0) || (nib_q > MAX_N4);

    // The counter runs nibble_cnt..1, and nibble (cnt-1) is the one to fold.
    always_comb begin
        cur_nib = 4'h0;
        for (int i = 0; i < MAX_NIBBLES; i++) begin
            if (cnt_q == 4'(i + 1)) cur_nib = data_q[4*i +: 4];
        end
        lfsr_nxt = fold(lfsr_q, cur_nib, mode_q, legacy_eff);
    end

    // State register
    always_ff @(posedge clk_tx) begin
        if (!reset_tx) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start) state_d = LOAD;
            LOAD:  state_d = cnt_illegal ? DONE : SHIFT;
            SHIFT: if (cnt_q == 4'd1) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy      = (state_q == LOAD) || (state_q == SHIFT);
        crc_valid = (state_q == DONE) && !err_q;
        crc_err   = (state_q == DONE) && err_q;
    end

    // Datapath
    always_ff @(posedge clk_tx) begin
        if (!reset_tx) begin
            mode_q  <= 1'b0;
            nib_q   <= 4'd0;
            data_q  <= '0;
            cnt_q   <= 4'd0;
            lfsr_q  <= 6'd0;
            err_q   <= 1'b0;
            crc_out <= 6'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_q <= crc_mode;
                        nib_q  <= nibble_cnt;
                        data_q <= data_in;
                        err_q  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (cnt_illegal) begin
                        err_q <= 1'b1;
                    end else begin
                        err_q <= 1'b0;
                        cnt_q <= nib_q;
                        if (legacy_eff)  lfsr_q <= {2'b00, CRC4_SEED};
                        else if (mode_q) lfsr_q <= CRC6_INIT;
                        else             lfsr_q <= CRC4_INIT;
                    end
                end
                SHIFT: begin
                    lfsr_q <= lfsr_nxt;
                    cnt_q  <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) crc_out <= lfsr_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sent_tx_crc_engine.md
Name: sent_tx_crc_engine

Overview:
- Parametrised CRC generator for the SENT transmitter.
- Computes the SAE J2716 CRC4 for fast-channel frames and short serial messages, and the CRC6 for enhanced serial messages.
- Input is a start/busy/done handshake from the TX control block.
- Processes one data nibble per clock, so a message of N nibbles takes N+2 cycles.

Parameters:
MAX_NIBBLES, 6, maximum data nibbles per message (legal range 1..8); sets the data_in width.
CRC4_SEED, 4'h5, CRC4 seed (preamble 0101).
CRC6_SEED, 6'h15, CRC6 seed (preamble 010101).

Ports:
clk_tx  input  1  TX clock, rising edge.
reset_tx  input  1  synchronous reset, active-low; sampled on the rising edge of clk_tx.
start  input  1  one-cycle request; sampled only in IDLE.
crc_mode  input  1  0 = CRC4 (poly x^4+x^3+x^2+1), 1 = CRC6 (poly x^6+x^4+x^3+1).
nibble_cnt  input  4  number of data nibbles, 1..MAX_NIBBLES.
data_in  input  4*MAX_NIBBLES  data; the first nibble is data_in[4*nibble_cnt-1 -: 4], MSB-first; unused upper bits are ignored.
busy  output  1  high from the cycle after start is accepted until done.
crc_out  output  6  result; CRC4 occupies [3:0] with [5:4] = 0; held until the next accept.
crc_valid  output  1  one-cycle pulse with crc_out.
crc_err  output  1  one-cycle pulse instead of crc_valid when nibble_cnt is illegal.

Behaviour:
- Reset (reset_tx = 0 at an edge): state = IDLE, busy = 0, crc_out = 0, crc_valid = 0, crc_err = 0, all internal registers cleared.
- Reset mid-operation aborts the message; no pulse is produced.
- Result definition: remainder of {seed, data bits, k zero bits} divided by P, where k = 4 for CRC4 and 6 for CRC6. This is the SAE-recommended augmented CRC.
- Implementation form: a non-augmented LFSR, fed MSB-first at 4 bits per cycle. Initial value is seed·x^k mod P: 4'h3 for CRC4, 6'h3B for CRC6.
- States:
  - IDLE: busy = 0. On start = 1, latch crc_mode, nibble_cnt and data_in, then go to LOAD. Inputs are don't-care after they are latched.
  - LOAD, 1 cycle: busy = 1. If nibble_cnt is 0 or greater than MAX_NIBBLES, go to DONE with the error flag set. Otherwise load the LFSR init value, set the nibble counter to nibble_cnt, and go to SHIFT.
  - SHIFT: fold one nibble per cycle and decrement the counter. When the counter reaches 0, go to DONE.
  - DONE, 1 cycle: drive crc_out and pulse crc_valid, or pulse crc_err with crc_out unchanged. busy = 0 in this cycle. Next state is IDLE.
- Latency: from the start edge to the crc_valid cycle is nibble_cnt+2 cycles. Example: 6 nibbles gives valid 8 cycles after start.
- Back-to-back operation: start may be asserted in the cycle after DONE.
- start while busy: ignored, with no queueing and no error.
- start and reset in the same cycle: reset wins.
- crc_valid and crc_err are never high in the same cycle.

Optional Feature:
- Macro: SENT_CRC_LEGACY_EN.
- When defined:
  - Adds input port legacy_crc (1 bit), latched at accept.
  - When legacy_crc = 1 and crc_mode = 0, the result is the J2716-2007 legacy CRC4: the remainder of {seed, data} divided by P, with no zero augmentation.
  - legacy_crc is ignored in CRC6 mode. Latency is unchanged.
- When undefined: the port is absent and only the augmented CRC is produced.

Test Plan:
- CRC4, nibble_cnt = 3, data 12'h000 -> crc_valid 5 cycles after start, crc_out = 6'h09.
- CRC4, nibble_cnt = 3, data 12'hFFF -> crc_out = 6'h05.
- CRC4, nibble_cnt = 6, data 24'h000000 -> crc_out = 6'h05, 8-cycle latency; start pulsed during busy is ignored with no second valid.
- CRC6, nibble_cnt = 6, data 24'h000000 -> crc_out = 6'h26; then start again in the cycle after DONE -> second identical result 8 cycles later.
- nibble_cnt = 0 and nibble_cnt = 7 -> crc_err pulse 2 cycles after start, crc_valid stays low, crc_out keeps its previous value.
- reset_tx low during SHIFT -> busy = 0 and crc_out = 0 on the next edge, no pulse. With SENT_CRC_LEGACY_EN defined, legacy CRC4 of 12'h000 -> crc_out = 6'h06.
